// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch redirects,
// data-memory wait states with timeout, and halt.
module hazard_control_unit #(
    parameter int         MAX_WAIT = 64,
    parameter int         CNT_W    = 16,
    parameter logic [3:0] OP_LW    = 4'b1000,
    parameter logic [3:0] OP_HLT   = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [3:0]       ex_opcode,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [3:0]       wb_opcode,
    output logic             pc_wen,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_stall,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_HALTED   = 2'd2;

    localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;
    logic        timeout_set;
    logic        apply_rules;
    logic        load_use;

    // Decode opcode is not needed for hazard detection; tied off so lint sees it consumed.
    logic unused_id_opcode;
    assign unused_id_opcode = ^id_opcode;

    assign load_use = (ex_opcode == OP_LW) && (ex_rd != 4'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign halted = (state == S_HALTED);

    always_comb begin
        pc_wen      = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_stall = 1'b0;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        apply_rules = 1'b0;

        if (!rst_n) begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (wb_opcode == OP_HLT) begin
                        // MEM/WB keeps moving so the HLT itself retires.
                        pc_wen      = 1'b0;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_stall = 1'b1;
                        state_nxt   = S_HALTED;
                    end else if (mem_req && !mem_ready) begin
                        pc_wen      = 1'b0;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_stall = 1'b1;
                        memwb_stall = 1'b1;
                        state_nxt   = S_MEM_WAIT;
                        wait_nxt    = 16'd1;
                    end else begin
                        apply_rules = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_wen      = 1'b0;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_stall = 1'b1;
                        memwb_stall = 1'b1;
                        if (wait_cnt == WAIT_LIMIT) begin
                            timeout_set = 1'b1;
                            state_nxt   = S_HALTED;
                        end else begin
                            wait_nxt = wait_cnt + 16'd1;
                        end
                    end else begin
                        // Release cycle: the held branch / load-use resolve now.
                        apply_rules = 1'b1;
                        state_nxt   = S_RUN;
                        wait_nxt    = 16'd0;
                    end
                end
                S_HALTED: begin
                    pc_wen      = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_stall = 1'b1;
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase

            if (apply_rules) begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_wen     = 1'b0;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_RUN;
            wait_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_wen && (state != S_HALTED) && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: one default instance and one with a
// short wait limit and a 2-bit stall counter.
module tb_hazard_control_unit;

    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] HLT = 4'b1111;

    // {pc_wen, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_stall, halted, mem_timeout}
    localparam logic [8:0] C_RST     = 9'b001010000;
    localparam logic [8:0] C_NORM    = 9'b100000000;
    localparam logic [8:0] C_LU      = 9'b010010000;
    localparam logic [8:0] C_BR      = 9'b101010000;
    localparam logic [8:0] C_STALL   = 9'b010101100;
    localparam logic [8:0] C_HLT     = 9'b010101000;
    localparam logic [8:0] C_HALT    = 9'b010101110;
    localparam logic [8:0] C_HALT_TO = 9'b010101111;
    localparam logic [8:0] C_RST_TO  = 9'b001010011;

    typedef struct {
        bit         dsel;
        string      tag;
        logic [8:0] ctl;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [3:0] id_opcode = 4'h1, id_rs = '0, id_rt = '0, ex_opcode = '0, ex_rd = '0, wb_opcode = '0;
    logic       id_uses_rt = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_wen_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a;
    logic        exmem_stall_a, memwb_stall_a, halted_a, mem_timeout_a;
    logic [15:0] stall_cycles_a;
    logic        pc_wen_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b;
    logic        exmem_stall_b, memwb_stall_b, halted_b, mem_timeout_b;
    logic [1:0]  stall_cycles_b;

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {pc_wen_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a,
                    exmem_stall_a, memwb_stall_a, halted_a, mem_timeout_a};
    assign ctl_b = {pc_wen_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b,
                    exmem_stall_b, memwb_stall_b, halted_b, mem_timeout_b};

    hazard_control_unit u_dut_a (
        .clk(clk), .rst_n(rst_a), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_opcode(wb_opcode), .pc_wen(pc_wen_a), .ifid_stall(ifid_stall_a),
        .ifid_flush(ifid_flush_a), .idex_stall(idex_stall_a), .idex_flush(idex_flush_a),
        .exmem_stall(exmem_stall_a), .memwb_stall(memwb_stall_a), .halted(halted_a),
        .mem_timeout(mem_timeout_a), .stall_cycles(stall_cycles_a)
    );

    hazard_control_unit #(.MAX_WAIT(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_opcode(wb_opcode), .pc_wen(pc_wen_b), .ifid_stall(ifid_stall_b),
        .ifid_flush(ifid_flush_b), .idex_stall(idex_stall_b), .idex_flush(idex_flush_b),
        .exmem_stall(exmem_stall_b), .memwb_stall(memwb_stall_b), .halted(halted_b),
        .mem_timeout(mem_timeout_b), .stall_cycles(stall_cycles_b)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   cur_dut  = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One cycle of stimulus; the expected response is queued unless tag is empty.
    task automatic cyc(input string tag, input logic rst,
                       input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                       input logic [3:0] exop, input logic [3:0] exrd,
                       input logic br, input logic mreq, input logic mrdy,
                       input logic [3:0] wbop, input logic [8:0] ectl, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a = cur_dut ? 1'b0 : rst;
        rst_b = cur_dut ? rst : 1'b0;
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_opcode = exop; ex_rd = exrd;
        branch_taken = br; mem_req = mreq; mem_ready = mrdy; wb_opcode = wbop;
        if (tag != "") begin
            e.dsel = cur_dut; e.tag = tag; e.ctl = ectl; e.cnt = ecnt;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, "_ctl"}, mon_e.dsel ? int'(ctl_b) : int'(ctl_a), int'(mon_e.ctl));
            check_eq({mon_e.tag, "_cnt"},
                     mon_e.dsel ? int'(stall_cycles_b) : int'(stall_cycles_a), mon_e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within bound");
        $fatal(1);
    end

    initial begin
        // Default instance: reset, load-use, branch priority, memory wait, halt.
        cur_dut = 1'b0;
        cyc("",          0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  0);
        cyc("rst",       0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  0);
        cyc("rel",       1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 0);
        cyc("lu_rs",     1, 3, 0, 0, LW, 3, 0, 0, 0, 0,   C_LU,   0);
        cyc("lu_clr",    1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 1);
        cyc("lu_r0",     1, 0, 0, 1, LW, 0, 0, 0, 0, 0,   C_NORM, 1);
        cyc("lu_rt",     1, 2, 5, 1, LW, 5, 0, 0, 0, 0,   C_LU,   1);
        cyc("rt_unused", 1, 2, 5, 0, LW, 5, 0, 0, 0, 0,   C_NORM, 2);
        cyc("br_lu",     1, 3, 0, 0, LW, 3, 1, 0, 0, 0,   C_BR,   2);
        cyc("rst2",      0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  2);
        cyc("rel2",      1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 0);
        for (int i = 0; i < 5; i++)
            cyc("mw",    1, 3, 0, 0, LW, 3, 1, 1, 0, 0,   C_STALL, i);
        cyc("mw_rel",    1, 3, 0, 0, LW, 3, 1, 1, 1, 0,   C_BR,   5);
        cyc("mw_cnt",    1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 5);
        cyc("mw2",       1, 0, 0, 0, 0,  0, 0, 1, 0, 0,   C_STALL, 5);
        cyc("rst_mw",    0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  6);
        cyc("post_rst",  1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 0);
        cyc("mw3",       1, 3, 0, 0, LW, 3, 0, 1, 0, 0,   C_STALL, 0);
        cyc("mw3_rel",   1, 3, 0, 0, LW, 3, 0, 1, 1, 0,   C_LU,   1);
        cyc("hlt",       1, 0, 0, 0, 0,  0, 0, 0, 0, HLT, C_HLT,  2);
        cyc("halted",    1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_HALT, 3);
        cyc("halted2",   1, 0, 0, 0, 0,  0, 0, 1, 1, 0,   C_HALT, 3);

        // Short-limit instance: timeout, sticky flag, counter saturation, halt.
        cur_dut = 1'b1;
        cyc("",          0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  0);
        cyc("b_rst",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST,  0);
        cyc("b_rel",     1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM, 0);
        for (int i = 0; i < 4; i++)
            cyc("to_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  C_STALL, i);
        cyc("to_hit",    1, 0, 0, 0, 0,  0, 0, 1, 0, 0,   C_STALL,   3);
        cyc("to_halt",   1, 0, 0, 0, 0,  0, 0, 1, 0, 0,   C_HALT_TO, 3);
        cyc("to_sticky", 1, 0, 0, 0, 0,  0, 0, 1, 1, 0,   C_HALT_TO, 3);
        cyc("to_rst",    0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_RST_TO,  3);
        cyc("b_rel2",    1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_NORM,    0);
        for (int i = 0; i < 5; i++)
            cyc("sat",   1, 7, 0, 0, LW, 7, 0, 0, 0, 0,   C_LU, (i > 3) ? 3 : i);
        cyc("b_hlt",     1, 0, 0, 0, 0,  0, 0, 0, 0, HLT, C_HLT,  3);
        cyc("b_halted",  1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   C_HALT, 3);
        cyc("b_halted2", 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,   C_HALT, 3);

        @(negedge clk);
        #1;
        check_eq("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
